// File: rtl/fft_pkg.sv
// Shared types for the 64-point FFT datapath and its front-end frame loader.
package fft_pkg;

    localparam int N_POINTS = 64;
    localparam int DATA_W   = 16;

    typedef logic [DATA_W-1:0] sample_t;
    typedef sample_t frame_t [N_POINTS-1:0];

    typedef enum logic [1:0] {
        FILL,
        LAUNCH,
        HOLD
    } loader_state_e;

endpackage

// File: rtl/fft_frame_loader.sv
// Collects a serial valid/ready stream of complex samples into a parallel
// 64-entry frame, launches the FFT, and freezes the frame while it computes.
module fft_frame_loader #(
    parameter int N_POINTS   = 64,
    parameter int DATA_W     = 16,
    parameter int FFT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic              in_last,
    output logic [DATA_W-1:0] out_re [N_POINTS-1:0],
    output logic [DATA_W-1:0] out_im [N_POINTS-1:0],
    output logic              start,
    output logic              busy,
    output logic              frame_err
);
    import fft_pkg::*;

    localparam int IDX_W  = $clog2(N_POINTS);
    localparam int HOLD_W = $clog2(FFT_CYCLES + 1);

    loader_state_e     state;
    logic [IDX_W-1:0]  wr_idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic              accept;
    logic              idx_last;

    // Gated by rst so upstream never sees ready during a reset cycle.
    assign in_ready = (state == FILL) && !rst;
    assign accept   = in_valid && in_ready;
    assign idx_last = (wr_idx == IDX_W'(N_POINTS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            wr_idx    <= '0;
            hold_cnt  <= '0;
            start     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            start     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        frame_err <= (in_last != idx_last);
                        if (idx_last) begin
                            state  <= LAUNCH;
                            start  <= 1'b1;
                            busy   <= 1'b1;
                            wr_idx <= '0;
                        end else if (in_last) begin
                            // Short frame: drop it and realign on the next beat.
                            wr_idx <= '0;
                        end else begin
                            wr_idx <= wr_idx + IDX_W'(1);
                        end
                    end
                end
                LAUNCH: begin
                    state    <= HOLD;
                    hold_cnt <= '0;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_W'(FFT_CYCLES - 1)) begin
                        state    <= FILL;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Frame buffer drives the FFT directly; only written while filling.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_POINTS; i++) begin
                out_re[i] <= '0;
                out_im[i] <= '0;
            end
        end else if (accept) begin
            out_re[wr_idx] <= in_re;
            out_im[wr_idx] <= in_im;
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Randomized bench for fft_frame_loader against a frame/event reference model.
module tb_fft_frame_loader;
    import fft_pkg::*;

    localparam int FFT_CYCLES = 128;

    logic    clk = 1'b0;
    logic    rst;
    logic    in_valid;
    logic    in_ready;
    sample_t in_re;
    sample_t in_im;
    logic    in_last;
    sample_t out_re [N_POINTS-1:0];
    sample_t out_im [N_POINTS-1:0];
    logic    start;
    logic    busy;
    logic    frame_err;

    fft_frame_loader #(
        .N_POINTS  (N_POINTS),
        .DATA_W    (DATA_W),
        .FFT_CYCLES(FFT_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_re    (in_re),
        .in_im    (in_im),
        .in_last  (in_last),
        .out_re   (out_re),
        .out_im   (out_im),
        .start    (start),
        .busy     (busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    sample_t m_re [N_POINTS];
    sample_t m_im [N_POINTS];
    int      m_idx;
    int      exp_start[$];
    int      exp_err[$];
    int      got_start[$];
    int      got_err[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) @cyc %0d", tag, obs, obs, exp, exp, cyc);
        end
    endtask

    // Advance one clock; observe just after the edge and log output pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (start === 1'b1) got_start.push_back(cyc);
        if (frame_err === 1'b1) got_err.push_back(cyc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_POINTS; i++) begin
            m_re[i] = '0;
            m_im[i] = '0;
        end
        m_idx = 0;
    endtask

    task automatic compare_frame(input string tag);
        for (int i = 0; i < N_POINTS; i++) begin
            check($sformatf("%s_re[%0d]", tag, i), 32'(out_re[i]), 32'(m_re[i]));
            check($sformatf("%s_im[%0d]", tag, i), 32'(out_im[i]), 32'(m_im[i]));
        end
    endtask

    task automatic check_events(input string tag);
        int n;
        check({tag, "_start_count"}, got_start.size(), exp_start.size());
        n = (got_start.size() < exp_start.size()) ? got_start.size() : exp_start.size();
        for (int i = 0; i < n; i++) check({tag, "_start_cycle"}, got_start[i], exp_start[i]);
        check({tag, "_err_count"}, got_err.size(), exp_err.size());
        n = (got_err.size() < exp_err.size()) ? got_err.size() : exp_err.size();
        for (int i = 0; i < n; i++) check({tag, "_err_cycle"}, got_err[i], exp_err[i]);
        got_start.delete();
        exp_start.delete();
        got_err.delete();
        exp_err.delete();
    endtask

    // Presents one beat (optionally after random idle gaps) and holds it until accepted.
    task automatic send_beat(input sample_t re, input sample_t im, input logic last, input bit gaps);
        int to;
        if (gaps) begin
            for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_re    = re;
        in_im    = im;
        in_last  = last;
        in_valid = 1'b1;
        to = 0;
        while (in_ready !== 1'b1 && to < 2 * FFT_CYCLES + 10) begin
            tick();
            to++;
        end
        if (in_ready !== 1'b1) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        m_re[m_idx] = re;
        m_im[m_idx] = im;
        if (m_idx == N_POINTS - 1) exp_start.push_back(cyc + 1);
        if (last != (m_idx == N_POINTS - 1)) exp_err.push_back(cyc + 1);
        m_idx = (last || m_idx == N_POINTS - 1) ? 0 : m_idx + 1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_pos, input bit gaps, input bit ramp);
        sample_t re, im;
        for (int i = 0; i < n; i++) begin
            if (ramp) begin
                re = sample_t'(i);
                im = sample_t'(-i);
            end else begin
                re = sample_t'($urandom);
                im = sample_t'($urandom);
            end
            send_beat(re, im, (i == last_pos), gaps);
        end
    endtask

    task automatic wait_idle();
        int to = 0;
        while (in_ready !== 1'b1 && to < FFT_CYCLES + 20) begin
            tick();
            to++;
        end
        check("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic do_reset(input string tag);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check({tag, "_ready_in_rst"}, 32'(in_ready), 32'd0);
        tick();
        model_reset();
        check({tag, "_ready_in_rst2"}, 32'(in_ready), 32'd0);
        check({tag, "_start"}, 32'(start), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        compare_frame({tag, "_zero"});
        rst = 1'b0;
        #1;
        check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int s, b, viol, ret;
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
        in_last  = 1'b0;
        rst      = 1'b1;
        model_reset();
        tick();
        do_reset("rst0");

        // Ramp frame, back to back.
        send_frame(N_POINTS, N_POINTS - 1, 1'b0, 1'b1);
        check("ramp_start_now", 32'(start), 32'd1);
        check("ramp_busy_now", 32'(busy), 32'd1);
        check_events("ramp");
        compare_frame("ramp");

        // Hold window: upstream keeps pushing 0x7FFF which must be ignored.
        s = cyc;
        b = (busy === 1'b1) ? 1 : 0;
        viol = (in_ready !== 1'b0) ? 1 : 0;
        ret = -1;
        in_re = 16'h7FFF;
        in_im = 16'h7FFF;
        in_last = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < FFT_CYCLES + 10; k++) begin
            tick();
            if (in_ready === 1'b1) begin
                in_valid = 1'b0;
                ret = cyc - s;
                break;
            end
            if (busy === 1'b1) b++;
            if (in_ready !== 1'b0) viol++;
        end
        in_valid = 1'b0;
        check("hold_ready_return", 32'(ret), 32'(1 + FFT_CYCLES));
        check("hold_busy_len", 32'(b), 32'(1 + FFT_CYCLES));
        check("hold_ready_low", 32'(viol), 32'd0);
        check("hold_busy_clear", 32'(busy), 32'd0);
        compare_frame("hold");
        check_events("hold");

        // Early in_last on beat 10, then a clean frame.
        send_frame(11, 10, 1'b0, 1'b0);
        tick();
        tick();
        check_events("early_last");
        send_frame(N_POINTS, N_POINTS - 1, 1'b0, 1'b0);
        check_events("after_early");
        compare_frame("after_early");
        wait_idle();

        // Missing in_last: error and launch together.
        send_frame(N_POINTS, -1, 1'b0, 1'b0);
        check("nolast_start", 32'(start), 32'd1);
        check("nolast_err", 32'(frame_err), 32'd1);
        check_events("nolast");
        compare_frame("nolast");
        wait_idle();

        // Random valid gaps.
        send_frame(N_POINTS, N_POINTS - 1, 1'b1, 1'b0);
        check_events("gaps");
        compare_frame("gaps");
        wait_idle();

        // Reset 30 beats into FILL.
        send_frame(30, -1, 1'b0, 1'b0);
        check_events("pre_rst_fill");
        do_reset("rst_fill");
        for (int k = 0; k < 3; k++) tick();
        check_events("post_rst_fill");
        send_frame(N_POINTS, N_POINTS - 1, 1'b1, 1'b0);
        check_events("reload1");
        compare_frame("reload1");

        // Reset 100 cycles into HOLD.
        for (int k = 0; k < 100; k++) tick();
        check("midhold_busy", 32'(busy), 32'd1);
        check_events("pre_rst_hold");
        do_reset("rst_hold");
        for (int k = 0; k < 3; k++) tick();
        check_events("post_rst_hold");
        send_frame(N_POINTS, N_POINTS - 1, 1'b0, 1'b0);
        check_events("reload2");
        compare_frame("reload2");
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
